// File: rtl/i281_pkg.sv
// Shared definitions for the i281 code-memory loader: memory geometry,
// loader state encoding and the header validity rule.
package i281_pkg;

    localparam int CODE_ADDR_W   = 6;
    localparam int INSTR_W       = 16;
    localparam int CODE_DEPTH    = 64;
    localparam int LOADER_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HDR  = 3'd1,
        HI   = 3'd2,
        LO   = 3'd3,
        WR   = 3'd4,
        DONE = 3'd5,
        ERR  = 3'd6
    } loader_state_e;

    // A header is usable when it asks for at least one word and no more
    // words than the code memory holds.
    function automatic logic header_ok(input logic [LOADER_BYTE_W-1:0] n,
                                       input logic [LOADER_BYTE_W:0]   depth);
        return (n != {LOADER_BYTE_W{1'b0}}) && ({1'b0, n} <= depth);
    endfunction

endpackage

// File: rtl/code_loader.sv
// Byte-stream loader for the 64x16 code memory. Takes a header byte (word
// count N) followed by N instructions sent high byte first, writes them at
// addresses 0..N-1 and holds the CPU while the load is running.
module code_loader
    import i281_pkg::*;
#(
    parameter int ADDR_W    = CODE_ADDR_W,
    parameter int DATA_W    = INSTR_W,
    parameter int BYTE_W    = LOADER_BYTE_W,
    parameter int NUM_WORDS = CODE_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_in,
    output logic              byte_ready,
    output logic              c1,
    output logic [ADDR_W-1:0] write_select,
    output logic [DATA_W-1:0] inp,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   word_count
);

    loader_state_e     state_r;
    loader_state_e     state_next_s;
    logic [ADDR_W:0]   n_r;
    logic [ADDR_W:0]   word_count_r;
    logic [ADDR_W:0]   wc_inc_s;
    logic [ADDR_W-1:0] addr_r;
    logic [ADDR_W-1:0] write_select_r;
    logic [BYTE_W-1:0] hi_r;
    logic [DATA_W-1:0] inp_r;
    logic              c1_r;
    logic              done_r;
    logic              err_r;
    logic              byte_ready_s;
    logic              busy_s;
    logic              accept_s;
    logic              hdr_ok_s;
    logic              last_word_s;

    assign accept_s    = byte_valid && byte_ready_s;
    assign hdr_ok_s    = header_ok(byte_in, 9'(NUM_WORDS));
    assign wc_inc_s    = word_count_r + {{ADDR_W{1'b0}}, 1'b1};
    assign last_word_s = (wc_inc_s == n_r);

    // Decode handshake readiness and busy from the current state.
    always_comb begin
        byte_ready_s = 1'b0;
        busy_s       = 1'b0;
        case (state_r)
            HDR, HI, LO: begin
                byte_ready_s = 1'b1;
                busy_s       = 1'b1;
            end
            WR:      busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Next-state logic; abort outranks both start and a byte accept.
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start) state_next_s = HDR;
                    else       state_next_s = state_r;
                end
                HDR: begin
                    if (accept_s) state_next_s = hdr_ok_s ? HI : ERR;
                    else          state_next_s = HDR;
                end
                HI: begin
                    if (accept_s) state_next_s = LO;
                    else          state_next_s = HI;
                end
                LO: begin
                    if (accept_s) state_next_s = WR;
                    else          state_next_s = LO;
                end
                WR: begin
                    if (last_word_s) state_next_s = DONE;
                    else             state_next_s = HI;
                end
                default: state_next_s = IDLE;
            endcase
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Datapath: header latch, byte assembly, registered write port and status.
    always_ff @(posedge clock) begin
        if (reset) begin
            n_r            <= {(ADDR_W+1){1'b0}};
            word_count_r   <= {(ADDR_W+1){1'b0}};
            addr_r         <= {ADDR_W{1'b0}};
            write_select_r <= {ADDR_W{1'b0}};
            hi_r           <= {BYTE_W{1'b0}};
            inp_r          <= {DATA_W{1'b0}};
            c1_r           <= 1'b0;
            done_r         <= 1'b0;
            err_r          <= 1'b0;
        end else if (abort) begin
            c1_r   <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else begin
            c1_r <= 1'b0;
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        done_r       <= 1'b0;
                        err_r        <= 1'b0;
                        word_count_r <= {(ADDR_W+1){1'b0}};
                        addr_r       <= {ADDR_W{1'b0}};
                    end
                end
                HDR: begin
                    if (accept_s) begin
                        if (hdr_ok_s) n_r   <= byte_in[ADDR_W:0];
                        else          err_r <= 1'b1;
                    end
                end
                HI: begin
                    if (accept_s) hi_r <= byte_in;
                end
                LO: begin
                    // Write port is loaded here so it is stable for all of WR.
                    if (accept_s) begin
                        c1_r           <= 1'b1;
                        write_select_r <= addr_r;
                        inp_r          <= {hi_r, byte_in};
                    end
                end
                WR: begin
                    word_count_r <= wc_inc_s;
                    addr_r       <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                    if (last_word_s) done_r <= 1'b1;
                end
                default: c1_r <= 1'b0;
            endcase
        end
    end

    assign byte_ready   = byte_ready_s;
    assign busy         = busy_s;
    assign cpu_hold     = busy_s;
    assign c1           = c1_r;
    assign write_select = write_select_r;
    assign inp          = inp_r;
    assign done         = done_r;
    assign err          = err_r;
    assign word_count   = word_count_r;

endmodule

// File: tb/tb_code_loader.sv
// Self-checking bench for code_loader: random instruction loads checked
// against a list model of the expected memory writes.
module tb_code_loader;

    localparam int NUM_WORDS = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        byte_ready;
    logic        c1;
    logic [5:0]  write_select;
    logic [15:0] inp;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [6:0]  word_count;

    int checks = 0;
    int errors = 0;

    logic [5:0]  got_addr[$];
    logic [15:0] got_data[$];
    int          ready_bad;

    code_loader dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_in(byte_in), .byte_ready(byte_ready),
        .c1(c1), .write_select(write_select), .inp(inp), .busy(busy),
        .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
    );

    always #5 clock = ~clock;

    // Shadow of the code memory write port: every write seen mid-cycle.
    always @(negedge clock) begin
        if (c1 === 1'b1) begin
            got_addr.push_back(write_select);
            got_data.push_back(inp);
            if (byte_ready !== 1'b0) ready_bad++;
        end
    end

    task automatic pulse_start;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic send_bytes(input logic [7:0] q[$], input int gap);
        foreach (q[i]) begin
            int cnt;
            cnt = 0;
            byte_valid = 1'b1;
            byte_in    = q[i];
            while (byte_ready !== 1'b1 && cnt < 64) begin
                @(negedge clock);
                cnt++;
            end
            checks++;
            if (cnt >= 64) begin
                errors++;
                $display("FAIL send_timeout byte %0d: byte_ready=%b, required 1", i, byte_ready);
            end
            @(negedge clock);
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
            repeat (gap) @(negedge clock);
        end
        byte_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int cnt;
        cnt = 0;
        while (busy !== 1'b0 && cnt < 400) begin
            @(negedge clock);
            cnt++;
        end
        checks++;
        if (cnt >= 400) begin
            errors++;
            $display("FAIL idle_timeout: busy=%b, required 0", busy);
        end
        repeat (2) @(negedge clock);
    endtask

    task automatic do_load(input logic [7:0] hdr, input logic [15:0] words[$], input int gap);
        logic [7:0] q[$];
        got_addr.delete();
        got_data.delete();
        ready_bad = 0;
        pulse_start();
        q.push_back(hdr);
        if (hdr != 8'd0 && int'(hdr) <= NUM_WORDS) begin
            foreach (words[i]) begin
                q.push_back(words[i][15:8]);
                q.push_back(words[i][7:0]);
            end
        end
        send_bytes(q, gap);
        wait_idle();
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = 8'h00;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        checks++;
        if ({c1, write_select, inp, busy, cpu_hold, done, err, word_count, byte_ready} !== 36'd0) begin
            errors++;
            $display("FAIL reset_outputs: c1=%b ws=%h inp=%h busy=%b hold=%b done=%b err=%b wc=%0d rdy=%b, required all 0",
                     c1, write_select, inp, busy, cpu_hold, done, err, word_count, byte_ready);
        end
    endtask

    task automatic test_basic;
        logic [15:0] w[$];
        w = '{16'h1234, 16'hABCD};
        do_load(8'h02, w, 0);
        checks++;
        if (got_addr.size() !== 2) begin errors++; $display("FAIL basic_count: %0d writes, required 2", got_addr.size()); end
        for (int i = 0; i < 2 && i < got_addr.size(); i++) begin
            checks++;
            if (got_addr[i] !== 6'(i) || got_data[i] !== w[i]) begin
                errors++;
                $display("FAIL basic_write%0d: addr=%0d data=%h, required addr=%0d data=%h", i, got_addr[i], got_data[i], i, w[i]);
            end
        end
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || word_count !== 7'd2 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: done=%b err=%b wc=%0d busy=%b hold=%b, required 1 0 2 0 0", done, err, word_count, busy, cpu_hold);
        end
        checks++;
        if (ready_bad !== 0) begin errors++; $display("FAIL basic_ready_in_wr: %0d WR cycles with byte_ready=1, required 0", ready_bad); end
    endtask

    task automatic test_bad_header;
        logic [7:0]  hdrs[3];
        logic [15:0] none[$];
        hdrs[0] = 8'h00;
        hdrs[1] = 8'h41;
        hdrs[2] = 8'($urandom_range(65, 255));
        foreach (hdrs[k]) begin
            do_load(hdrs[k], none, 0);
            checks++;
            if (err !== 1'b1 || done !== 1'b0 || word_count !== 7'd0 || busy !== 1'b0 || got_addr.size() !== 0) begin
                errors++;
                $display("FAIL bad_header_%h: err=%b done=%b wc=%0d busy=%b writes=%0d, required 1 0 0 0 0",
                         hdrs[k], err, done, word_count, busy, got_addr.size());
            end
        end
    endtask

    // Random-content load of n words with the given byte gap, checked against the write list.
    task automatic test_load(input string name, input int n, input int gap);
        logic [15:0] w[$];
        int          bad;
        for (int i = 0; i < n; i++) w.push_back(16'($urandom));
        do_load(8'(n), w, gap);
        checks++;
        if (got_addr.size() !== n) begin errors++; $display("FAIL %s_count: %0d writes, required %0d", name, got_addr.size(), n); end
        bad = 0;
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            if (got_addr[i] !== 6'(i) || got_data[i] !== w[i]) begin
                if (bad == 0) $display("FAIL %s_write%0d: addr=%0d data=%h, required addr=%0d data=%h", name, i, got_addr[i], got_data[i], i, w[i]);
                bad++;
            end
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (done !== 1'b1 || err !== 1'b0 || word_count !== 7'(n) || busy !== 1'b0 || ready_bad !== 0) begin
            errors++;
            $display("FAIL %s_status: done=%b err=%b wc=%0d busy=%b rdy_in_wr=%0d, required 1 0 %0d 0 0", name, done, err, word_count, busy, ready_bad, n);
        end
    endtask

    task automatic test_abort;
        logic [15:0] w0;
        logic [7:0]  q[$];
        w0 = 16'($urandom);
        got_addr.delete();
        got_data.delete();
        pulse_start();
        q = '{8'h04, w0[15:8], w0[7:0], 8'($urandom)};
        send_bytes(q, 0);
        byte_valid = 1'b1; byte_in = 8'($urandom); abort = 1'b1;
        @(negedge clock);
        abort = 1'b0; byte_valid = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0 || byte_ready !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b err=%b rdy=%b, required 0 0 0 0", busy, done, err, byte_ready);
        end
        repeat (6) @(negedge clock);
        checks++;
        if (got_addr.size() !== 1 || got_addr[0] !== 6'd0 || got_data[0] !== w0) begin
            errors++;
            $display("FAIL abort_writes: %0d writes first=%0d/%h, required 1 write 0/%h", got_addr.size(), got_addr[0], got_data[0], w0);
        end
        test_load("reload_after_abort", 2, 0);
    endtask

    task automatic test_reset_mid_load;
        logic [15:0] w0;
        logic [7:0]  q[$];
        w0 = 16'($urandom);
        got_addr.delete();
        got_data.delete();
        pulse_start();
        q = '{8'h03, w0[15:8]};
        send_bytes(q, 0);
        pulse_start();
        checks++;
        if (busy !== 1'b1 || byte_ready !== 1'b1 || word_count !== 7'd0) begin
            errors++;
            $display("FAIL start_while_busy: busy=%b rdy=%b wc=%0d, required 1 1 0", busy, byte_ready, word_count);
        end
        q = '{w0[7:0]};
        send_bytes(q, 0);
        @(negedge clock);
        reset = 1'b1; start = 1'b1;
        @(negedge clock);
        reset = 1'b0; start = 1'b0;
        checks++;
        if ({c1, write_select, inp, busy, cpu_hold, done, err, word_count, byte_ready} !== 36'd0) begin
            errors++;
            $display("FAIL reset_mid_load: c1=%b ws=%h inp=%h busy=%b hold=%b done=%b err=%b wc=%0d rdy=%b, required all 0",
                     c1, write_select, inp, busy, cpu_hold, done, err, word_count, byte_ready);
        end
        repeat (4) @(negedge clock);
        checks++;
        if (got_addr.size() !== 1 || got_addr[0] !== 6'd0 || got_data[0] !== w0) begin
            errors++;
            $display("FAIL reset_mid_writes: %0d writes first=%0d/%h, required 1 write 0/%h", got_addr.size(), got_addr[0], got_data[0], w0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_header();
        test_load("full", NUM_WORDS, 0);
        test_load("gapped", 3, 3);
        test_abort();
        test_reset_mid_load();
        for (int r = 0; r < 5; r++) test_load("random", int'($urandom_range(1, 8)), int'($urandom_range(0, 2)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/code_loader.md
Name: code_loader

Overview:
Upstream feeder for the 64x16 code memory.
- Accepts a byte stream over a valid/ready handshake. The stream is one header byte (word count N), then N instructions, each sent high byte first.
- Assembles each 16-bit instruction and drives the code memory write port (c1, write_select, inp) at sequential addresses from 0.
- Holds the CPU off (cpu_hold) while loading is in progress.

Parameters:
ADDR_W, 6, code memory address width
DATA_W, 16, instruction width (must equal 2*BYTE_W)
BYTE_W, 8, input stream width
NUM_WORDS, 64, code memory depth; maximum legal N

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a load; sampled in IDLE, DONE, ERR
abort  in  1  synchronous abort; returns to IDLE next edge
byte_valid  in  1  byte_in holds a valid byte
byte_in  in  BYTE_W  stream byte
byte_ready  out  1  loader can accept a byte this cycle
c1  out  1  code memory write enable, one cycle per word
write_select  out  ADDR_W  code memory write address
inp  out  DATA_W  instruction to write
busy  out  1  load in progress
cpu_hold  out  1  equals busy; stalls the CPU/PC
done  out  1  level: last load completed successfully
err  out  1  level: last load rejected (bad header)
word_count  out  ADDR_W+1  words written in the current/last load

Behaviour:
- Reset (synchronous, active-high): state=IDLE, all outputs 0. Reset overrides abort and start in the same cycle. Reset mid-load leaves already-written words in memory and issues no further write.
- Handshake: a byte is accepted at a rising edge when byte_valid && byte_ready. byte_ready is combinational from state: 1 only in HDR, HI, LO. byte_in is ignored when not accepted.
- FSM states: IDLE, HDR, HI, LO, WR, DONE, ERR.
- IDLE/DONE/ERR, on start=1:
  - go to HDR;
  - clear done, err, word_count;
  - set addr to 0.
- HDR, on accept:
  - N = byte_in;
  - if N==0 or N>NUM_WORDS, go to ERR (err=1);
  - otherwise latch N and go to HI.
- HI, on accept: latch the high byte, go to LO.
- LO, on accept: latch the low byte, go to WR.
- WR lasts exactly one cycle:
  - c1=1, write_select=addr, inp={hi,lo}, all registered so they are stable for the full cycle;
  - memory captures at the edge ending WR;
  - on that edge word_count increments and addr increments;
  - if word_count+1==N, go to DONE (done=1); else go to HI.
- c1=0 in every state except WR. write_select and inp hold their last values outside WR.
- busy=1 in HDR, HI, LO, WR; 0 otherwise. cpu_hold=busy.
- Throughput: at most one word per 3 cycles (HI, LO, WR). Back-to-back bytes are stalled during WR by byte_ready=0.
- start while busy is ignored.
- abort (not in reset) from any state goes to IDLE next edge: done=0, err=0, no c1 on that edge. abort takes priority over a simultaneous byte accept and over start.
- Address wrap: addr never exceeds N-1 ≤ NUM_WORDS-1. N=NUM_WORDS writes addresses 0..63 with no wrap.
- word_count holds its final value in DONE/ERR/IDLE until the next start.

Decomposition:
- Shared package (i281_pkg): CODE_ADDR_W=6, INSTR_W=16, CODE_DEPTH=64, and the loader state enum (IDLE, HDR, HI, LO, WR, DONE, ERR).
- No sub-module; single FSM plus datapath registers.
- code_loader outputs connect directly to codemem's c1/write_select/inp in the top level.

Test Plan:
- Reset, then start, then bytes 02,12,34,AB,CD sent with byte_valid held high -> c1 pulses twice: write_select=0 with inp=1234, then write_select=1 with inp=ABCD. Afterwards done=1, word_count=2, busy=0, and each WR cycle has byte_ready=0.
- Header 00, and separately header 41 (65) -> err=1, done=0, c1 never asserted, state returns to accepting start.
- Header 40 (64) followed by 128 bytes -> 64 writes at addresses 0..63 in order, word_count=64, done=1, no wrap write.
- Gapped byte_valid (1 cycle on, 3 off) with N=3 -> same three writes as with a continuous stream. Bytes presented while byte_ready=0 are not consumed.
- abort asserted in LO after N=4, word 0 written -> IDLE next edge, no further c1, done=err=0. A new start reloads from address 0.
- reset asserted during HI of word 1 -> all outputs 0 next edge. start asserted while busy is ignored (no restart, addr unchanged).
